// File: rtl/rgb_pkg.sv
// Shared types and helpers for the multi-LED RGB PWM driver.
// A colour code is {blink, R, G, B}; code_to_rgb extracts the colour enables.
package rgb_pkg;

   localparam int CODE_W    = 4;
   localparam int BLINK_BIT = 3;

   typedef struct packed {
      logic r;
      logic g;
      logic b;
   } rgb_t;

   function automatic rgb_t code_to_rgb(input logic [CODE_W-1:0] code);
      rgb_t c;
      c.r = code[2];
      c.g = code[1];
      c.b = code[0];
      return c;
   endfunction

endpackage

// File: rtl/rgb_pwm_channel.sv
// One RGB LED: active colour/duty/blink registers plus the registered
// PWM compare and blink gating that drive its three pins.
module rgb_pwm_channel
   import rgb_pkg::*;
#(
   parameter int PWM_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [CODE_W-1:0] code_in,
   input  logic [PWM_W-1:0]  bright_in,
   input  logic [PWM_W-1:0]  cnt,
   input  logic              phase_on,
   output rgb_t              drive
);

   logic             blink_q, blink_d;
   rgb_t             en_q, en_d;
   logic [PWM_W-1:0] duty_q, duty_d;
   rgb_t             drive_q, drive_d;
   logic             on;

   always_comb begin
      blink_d = blink_q;
      en_d    = en_q;
      duty_d  = duty_q;
      if (wr_en) begin
         blink_d = code_in[BLINK_BIT];
         en_d    = code_to_rgb(code_in);
         duty_d  = bright_in;
      end
   end

   // Output uses the pre-commit regs, so a commit on the wrap edge only shows
   // from the following edge onwards: the whole new period is clean.
   always_comb begin
      on        = (cnt < duty_q) & (~blink_q | phase_on);
      drive_d.r = on & en_q.r;
      drive_d.g = on & en_q.g;
      drive_d.b = on & en_q.b;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         blink_q <= 1'b0;
         en_q    <= '0;
         duty_q  <= '0;
         drive_q <= '0;
      end else begin
         blink_q <= blink_d;
         en_q    <= en_d;
         duty_q  <= duty_d;
         drive_q <= drive_d;
      end
   end

   assign drive = drive_q;

endmodule

// File: rtl/rgb_pwm_driver.sv
// Multi-LED RGB PWM driver: free-running PWM counter, shared blink phase and a
// single-slot update shadow that commits to one channel at each period wrap.
module rgb_pwm_driver
   import rgb_pkg::*;
#(
   parameter  int PWM_W         = 4,
   parameter  int NUM_CH        = 2,
   parameter  int BLINK_PERIODS = 2,
   localparam int SEL_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   output logic              ready,
   input  logic [SEL_W-1:0]  ch_sel,
   input  logic [CODE_W-1:0] code_in,
   input  logic [PWM_W-1:0]  bright,
   output logic [NUM_CH-1:0] R,
   output logic [NUM_CH-1:0] G,
   output logic [NUM_CH-1:0] B,
   output logic              period_tick
);

   localparam int BLINK_W = (BLINK_PERIODS > 1) ? $clog2(BLINK_PERIODS) : 1;
   localparam logic [BLINK_W-1:0] BLINK_MAX = BLINK_W'(BLINK_PERIODS - 1);
   localparam logic [PWM_W-1:0]   CNT_MAX   = {PWM_W{1'b1}};

   logic [PWM_W-1:0]   cnt_q, cnt_d;
   logic               tick_q, tick_d;
   logic               pending_q, pending_d;
   logic [SEL_W-1:0]   sh_sel_q, sh_sel_d;
   logic [CODE_W-1:0]  sh_code_q, sh_code_d;
   logic [PWM_W-1:0]   sh_bright_q, sh_bright_d;
   logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
   logic               phase_on_q, phase_on_d;

   logic wrap;
   logic accept;
   logic commit;

   // Handshake: an update transfers on a rising edge where load and ready are
   // both 1; ready depends only on the pending flag, never on load.
   assign wrap   = (cnt_q == CNT_MAX);
   assign accept = load & ~pending_q;
   assign commit = wrap & pending_q;
   assign ready  = ~pending_q;

   always_comb begin
      cnt_d       = cnt_q + PWM_W'(1);
      tick_d      = wrap;
      pending_d   = pending_q;
      sh_sel_d    = sh_sel_q;
      sh_code_d   = sh_code_q;
      sh_bright_d = sh_bright_q;
      if (commit) begin
         pending_d = 1'b0;
      end
      if (accept) begin
         pending_d   = 1'b1;
         sh_sel_d    = ch_sel;
         sh_code_d   = code_in;
         sh_bright_d = bright;
      end
   end

   always_comb begin
      blink_cnt_d = blink_cnt_q;
      phase_on_d  = phase_on_q;
      if (wrap) begin
         if (blink_cnt_q == BLINK_MAX) begin
            blink_cnt_d = '0;
            phase_on_d  = ~phase_on_q;
         end else begin
            blink_cnt_d = blink_cnt_q + BLINK_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q       <= '0;
         tick_q      <= 1'b0;
         pending_q   <= 1'b0;
         sh_sel_q    <= '0;
         sh_code_q   <= '0;
         sh_bright_q <= '0;
         blink_cnt_q <= '0;
         phase_on_q  <= 1'b1;
      end else begin
         cnt_q       <= cnt_d;
         tick_q      <= tick_d;
         pending_q   <= pending_d;
         sh_sel_q    <= sh_sel_d;
         sh_code_q   <= sh_code_d;
         sh_bright_q <= sh_bright_d;
         blink_cnt_q <= blink_cnt_d;
         phase_on_q  <= phase_on_d;
      end
   end

   assign period_tick = tick_q;

   // An out-of-range ch_sel matches no channel, so its commit is a no-op.
   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      localparam logic [SEL_W-1:0] CH_IDX = SEL_W'(i);
      rgb_t drive;

      rgb_pwm_channel #(.PWM_W(PWM_W)) u_ch (
         .clk       (clk),
         .rst       (rst),
         .wr_en     (commit & (sh_sel_q == CH_IDX)),
         .code_in   (sh_code_q),
         .bright_in (sh_bright_q),
         .cnt       (cnt_q),
         .phase_on  (phase_on_q),
         .drive     (drive)
      );

      assign R[i] = drive.r;
      assign G[i] = drive.g;
      assign B[i] = drive.b;
   end

endmodule

// File: tb/tb_rgb_pwm_driver.sv
// Bench for rgb_pwm_driver: per-cycle comparison against a period/wrap-count
// reference model, table-driven update vectors and directed corner sequences.
module tb_rgb_pwm_driver;

   localparam int PWM_W  = 4;
   localparam int NUM_CH = 2;
   localparam int BP     = 2;
   localparam int PERIOD = 16;

   logic        clk;
   logic        rst;
   logic        load;
   logic        ready;
   logic        ch_sel;
   logic [3:0]  code_in;
   logic [3:0]  bright;
   logic [1:0]  R, G, B;
   logic        period_tick;

   logic        load3;
   logic        ready3;
   logic [1:0]  ch_sel3;
   logic [3:0]  code3;
   logic [3:0]  bright3;
   logic [2:0]  R3, G3, B3;
   logic        tick3;

   rgb_pwm_driver #(.PWM_W(PWM_W), .NUM_CH(NUM_CH), .BLINK_PERIODS(BP)) u_dut (
      .clk         (clk),
      .rst         (rst),
      .load        (load),
      .ready       (ready),
      .ch_sel      (ch_sel),
      .code_in     (code_in),
      .bright      (bright),
      .R           (R),
      .G           (G),
      .B           (B),
      .period_tick (period_tick)
   );

   rgb_pwm_driver #(.PWM_W(PWM_W), .NUM_CH(3), .BLINK_PERIODS(BP)) u_dut3 (
      .clk         (clk),
      .rst         (rst),
      .load        (load3),
      .ready       (ready3),
      .ch_sel      (ch_sel3),
      .code_in     (code3),
      .bright      (bright3),
      .R           (R3),
      .G           (G3),
      .B           (B3),
      .period_tick (tick3)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int vec_n = 0;
   int err_n = 0;
   int cyc   = 0;

   // Reference model: position in period, wraps since reset, shadow and
   // active colour settings; expected pins are the on/off rule evaluated for
   // the previous cycle's counter value.
   int         m_cnt;
   int         m_wraps;
   logic       m_pending;
   logic       m_tick;
   int         m_sh_sel;
   logic [3:0] m_sh_code, m_sh_br;
   logic [3:0] m_code[NUM_CH];
   logic [3:0] m_br[NUM_CH];
   logic [1:0] m_r, m_g, m_b;

   task automatic model_step(input logic l, input int sel, input logic [3:0] code,
                             input logic [3:0] br, input logic r);
      bit wrap, ph, acc, com, on;
      if (r) begin
         m_cnt = 0; m_wraps = 0; m_pending = 0; m_tick = 0;
         m_sh_sel = 0; m_sh_code = 0; m_sh_br = 0;
         m_r = 0; m_g = 0; m_b = 0;
         for (int c = 0; c < NUM_CH; c++) begin
            m_code[c] = 0;
            m_br[c]   = 0;
         end
      end else begin
         wrap = (m_cnt == PERIOD - 1);
         ph   = ((m_wraps / BP) % 2) == 0;
         acc  = l && !m_pending;
         com  = wrap && m_pending;
         for (int c = 0; c < NUM_CH; c++) begin
            on     = (m_cnt < int'(m_br[c])) && (!m_code[c][3] || ph);
            m_r[c] = on && m_code[c][2];
            m_g[c] = on && m_code[c][1];
            m_b[c] = on && m_code[c][0];
         end
         m_tick = wrap;
         if (com) begin
            if (m_sh_sel < NUM_CH) begin
               m_code[m_sh_sel] = m_sh_code;
               m_br[m_sh_sel]   = m_sh_br;
            end
            m_pending = 0;
         end
         if (acc) begin
            m_sh_sel  = sel;
            m_sh_code = code;
            m_sh_br   = br;
            m_pending = 1;
         end
         if (wrap) m_wraps++;
         m_cnt = (m_cnt + 1) % PERIOD;
      end
   endtask

   task automatic cycle(input logic l, input int sel, input logic [3:0] code,
                        input logic [3:0] br, input logic r);
      logic [7:0] exp_v, act_v;
      load    = l;
      ch_sel  = sel[0];
      code_in = code;
      bright  = br;
      rst     = r;
      model_step(l, sel, code, br, r);
      @(posedge clk);
      #1;
      cyc++;
      exp_v = {m_r, m_g, m_b, ~m_pending, m_tick};
      act_v = {R, G, B, ready, period_tick};
      vec_n++;
      if (act_v !== exp_v) begin
         err_n++;
         $display("FAIL pins cyc %0d: {R,G,B,ready,tick} got %b want %b", cyc, act_v, exp_v);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) cycle(1'b0, 0, 4'd0, 4'd0, 1'b0);
   endtask

   task automatic check_int(input string name, input int got, input int want);
      vec_n++;
      if (got != want) begin
         err_n++;
         $display("FAIL %s: got %0d want %0d", name, got, want);
      end
   endtask

   task automatic wait_cnt(input int c);
      for (int k = 0; k < PERIOD && m_cnt != c; k++) idle(1);
   endtask

   task automatic wait_commit();
      for (int k = 0; k < 40 && m_pending; k++) idle(1);
      check_int("ready_after_commit", int'(ready), 1);
   endtask

   task automatic count_period(input int sel, output int nr, output int ng, output int nb);
      nr = 0; ng = 0; nb = 0;
      repeat (PERIOD) begin
         idle(1);
         nr += int'(R[sel]);
         ng += int'(G[sel]);
         nb += int'(B[sel]);
      end
   endtask

   typedef struct {
      int         sel;
      logic [3:0] code;
      logic [3:0] br;
      bit         drop;
      logic [3:0] dcode;
      logic [3:0] dbr;
      int         exp_r;
      int         exp_g;
      int         exp_b;
   } vec_t;

   vec_t tbl[6];

   initial begin
      int nr, ng, nb, first_tick, total, n8;

      tbl[0] = '{0, 4'b0011, 4'd4,  1'b0, 4'd0, 4'd0, 0, 4, 4};
      tbl[1] = '{1, 4'b0100, 4'd0,  1'b0, 4'd0, 4'd0, 0, 0, 0};
      tbl[2] = '{1, 4'b0100, 4'd15, 1'b0, 4'd0, 4'd0, 15, 0, 0};
      tbl[3] = '{1, 4'b0010, 4'd6,  1'b1, 4'b0100, 4'd9, 0, 6, 0};
      tbl[4] = '{0, 4'b0111, 4'd1,  1'b0, 4'd0, 4'd0, 1, 1, 1};
      tbl[5] = '{0, 4'b0000, 4'd15, 1'b0, 4'd0, 4'd0, 0, 0, 0};

      load3 = 0; ch_sel3 = 0; code3 = 0; bright3 = 0;

      // Reset held for three cycles, then first period_tick 16 cycles later.
      repeat (3) cycle(1'b0, 0, 4'd0, 4'd0, 1'b1);
      first_tick = -1;
      for (int k = 1; k <= 20; k++) begin
         idle(1);
         if (period_tick && first_tick < 0) first_tick = k;
      end
      check_int("first_tick", first_tick, 16);

      // Table of updates; entry 3 also offers a second load while busy.
      for (int e = 0; e < 6; e++) begin
         wait_cnt(5);
         cycle(1'b1, tbl[e].sel, tbl[e].code, tbl[e].br, 1'b0);
         check_int($sformatf("ready_low_%0d", e), int'(ready), 0);
         if (tbl[e].drop) cycle(1'b1, tbl[e].sel, tbl[e].dcode, tbl[e].dbr, 1'b0);
         wait_commit();
         count_period(tbl[e].sel, nr, ng, nb);
         check_int($sformatf("r_cnt_%0d", e), nr, tbl[e].exp_r);
         check_int($sformatf("g_cnt_%0d", e), ng, tbl[e].exp_g);
         check_int($sformatf("b_cnt_%0d", e), nb, tbl[e].exp_b);
      end

      // Blink: over four aligned periods, two at duty 8 and two dark.
      wait_cnt(5);
      cycle(1'b1, 0, 4'b1100, 4'd8, 1'b0);
      wait_commit();
      total = 0; n8 = 0;
      for (int p = 0; p < 4; p++) begin
         count_period(0, nr, ng, nb);
         total += nr;
         if (nr == 8) n8++;
      end
      check_int("blink_total", total, 16);
      check_int("blink_on_periods", n8, 2);

      // Reset mid-period with an update pending.
      wait_cnt(5);
      cycle(1'b1, 0, 4'b0111, 4'd15, 1'b0);
      wait_commit();
      wait_cnt(5);
      cycle(1'b1, 1, 4'b0111, 4'd15, 1'b0);
      wait_commit();
      wait_cnt(2);
      cycle(1'b1, 0, 4'b0001, 4'd3, 1'b0);
      wait_cnt(7);
      cycle(1'b0, 0, 4'd0, 4'd0, 1'b1);
      check_int("rst_pins", int'({R, G, B}), 0);
      check_int("rst_ready", int'(ready), 1);
      total = 0;
      repeat (40) begin
         idle(1);
         total += int'($countones({R, G, B}));
      end
      check_int("post_rst_dark", total, 0);

      // Three-channel build: invalid ch_sel completes without effect.
      load3 = 1; ch_sel3 = 2'd3; code3 = 4'b0111; bright3 = 4'd15;
      idle(1);
      load3 = 0;
      check_int("dut3_ready_low", int'(ready3), 0);
      idle(18);
      check_int("dut3_ready_back", int'(ready3), 1);
      total = 0;
      repeat (PERIOD) begin
         idle(1);
         total += int'($countones({R3, G3, B3}));
      end
      check_int("dut3_invalid_noop", total, 0);
      load3 = 1; ch_sel3 = 2'd1; code3 = 4'b0010; bright3 = 4'd5;
      idle(1);
      load3 = 0;
      idle(19);
      check_int("dut3_ch1_ready", int'(ready3), 1);
      ng = 0; total = 0;
      repeat (PERIOD) begin
         idle(1);
         ng += int'(G3[1]);
         total += int'($countones({R3, G3, B3}));
      end
      check_int("dut3_ch1_g", ng, 5);
      check_int("dut3_ch1_total", total, 5);

      // Random traffic against the model.
      for (int k = 0; k < 600; k++) begin
         cycle(($urandom_range(0, 3) == 0), int'($urandom_range(0, 1)),
               4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
               ($urandom_range(0, 149) == 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vec_n, err_n);
      $finish;
   end

endmodule
